// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Front end of the 5-stage MIPS pipeline: PC register, instruction-memory
//   request/ack handshake and the IF/ID pipeline register.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   FETCH   | request outstanding for PCF, waiting for imem_ack
//   HOLD    | word acked while decode was stalled; parked in the hold buffer
//   DISCARD | redirect hit a pending request; wait for its ack, drop the data
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   StallF                      1 = PC may advance, 0 = hold PC
//   StallD                      1 = IF/ID advances, 0 = IF/ID holds
//   PCSrcD, PCBranchD           taken branch and its target (wins over jump)
//   JumpD, PCJumpD              jump and its target
//   imem_req, imem_addr         instruction-memory request, word aligned
//   imem_rdata, imem_ack        instruction data and request completion
//   InstrD, PCPlus4D, ValidD    IF/ID register contents
//   FetchBusyF                  no instruction ready for decode this cycle
//
// Build option FETCH_PERF_CNT_EN adds saturating counters perf_fetched,
// perf_bubbles and perf_flushes.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes,
`endif
  output logic        FetchBusyF
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_en_q;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] instr_d, pc4_d;
  logic        valid_d;
  logic        redirect, ack_ok;
  logic [31:0] target, pc_plus4;

  assign redirect = StallD & (PCSrcD | JumpD);
  assign target   = (PCSrcD ? PCBranchD : PCJumpD) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  // req_en_q keeps the request low until the first clock after reset release
  assign imem_req  = req_en_q & (state_q != S_HOLD);
  assign imem_addr = (state_q == S_DISCARD) ? req_addr_q : pc_q;
  assign ack_ok    = imem_req & imem_ack;

  assign FetchBusyF = (state_q == S_HOLD) ? ~hold_valid_q
                                          : ~(ack_ok && state_q == S_FETCH);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    hold_valid_d = hold_valid_q;
    instr_d      = InstrD;
    pc4_d        = PCPlus4D;
    valid_d      = ValidD;
    // With decode advancing and nothing loaded, IF/ID takes a bubble/flush
    if (StallD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
    case (state_q)
      S_FETCH: begin
        if (ack_ok) begin
          if (redirect) begin
            pc_d = target;
          end else if (StallD) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            if (StallF) pc_d = pc_plus4;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_plus4;
            hold_valid_d = 1'b1;
            if (StallF) pc_d = pc_plus4;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          // memory still owes us the old word; keep presenting its address
          pc_d       = target;
          req_addr_d = pc_q;
          state_d    = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          hold_valid_d = 1'b0;
          pc_d         = target;
          state_d      = S_FETCH;
        end else if (StallD) begin
          instr_d      = hold_instr_q;
          pc4_d        = hold_pc4_q;
          valid_d      = hold_valid_q;
          hold_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (redirect) pc_d = target;
        if (ack_ok) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_en_q     <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= 32'd0;
      hold_valid_q <= 1'b0;
      InstrD       <= NOP_INSTR;
      PCPlus4D     <= 32'd0;
      ValidD       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      req_en_q     <= 1'b1;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_valid_q <= hold_valid_d;
      InstrD       <= instr_d;
      PCPlus4D     <= pc4_d;
      ValidD       <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
      perf_flushes <= 32'd0;
    end else begin
      if (StallD && valid_d && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (StallD && !valid_d && perf_bubbles != 32'hFFFF_FFFF)
        perf_bubbles <= perf_bubbles + 32'd1;
      if (redirect && perf_flushes != 32'hFFFF_FFFF)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  logic        clk, rst_n;
  logic        StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, FetchBusyF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_flushes;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int lat;
  int cnt;

  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes),
`endif
    .FetchBusyF(FetchBusyF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: acks after lat wait cycles, data = address ^ A5A5_0000
  always_comb begin
    imem_ack   = imem_req && (cnt >= lat);
    imem_rdata = imem_addr ^ 32'hA5A5_0000;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // handshake monitor: pending request must keep req and address stable
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  always @(negedge clk) begin
    #2;
    if (rst_n && pend) begin
      chk("hs_req_held", {31'd0, imem_req}, 32'd1);
      chk("hs_addr_held", imem_addr, paddr);
    end
    if (rst_n && imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    pend  = rst_n && imem_req && !imem_ack;
    paddr = imem_addr;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'd0; PCJumpD = 32'd0; lat = 0;

    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, 32'd0);
    chk("rst_pc4", PCPlus4D, 32'd0);
    chk("rst_busy", {31'd0, FetchBusyF}, 32'd1);
    rst_n = 1'b1;

    // zero-wait streaming
    step();
    chk("zw_req", {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr, 32'h0);
    chk("zw_valid0", {31'd0, ValidD}, 32'd0);
    chk("zw_busy0", {31'd0, FetchBusyF}, 32'd0);
    step();
    chk("zw_addr4", imem_addr, 32'h4);
    chk("zw_instr0", InstrD, 32'hA5A5_0000);
    chk("zw_pc4_0", PCPlus4D, 32'h4);
    chk("zw_valid1", {31'd0, ValidD}, 32'd1);
    step();
    chk("zw_addr8", imem_addr, 32'h8);
    chk("zw_instr4", InstrD, 32'hA5A5_0004);
    chk("zw_valid2", {31'd0, ValidD}, 32'd1);

    // decode stall while word@8 is acked
    StallD = 1'b0;
    step();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr", InstrD, 32'hA5A5_0004);
    chk("hold_valid", {31'd0, ValidD}, 32'd1);
    chk("hold_busy", {31'd0, FetchBusyF}, 32'd0);
    step();
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_instr2", InstrD, 32'hA5A5_0004);
    StallD = 1'b1;
    step();
    chk("unhold_instr", InstrD, 32'hA5A5_0008);
    chk("unhold_pc4", PCPlus4D, 32'hC);
    chk("unhold_addr", imem_addr, 32'hC);
    chk("unhold_req", {31'd0, imem_req}, 32'd1);

    // branch while request to 12 outstanding, 2 wait cycles
    lat = 2; PCSrcD = 1'b1; PCBranchD = 32'h100;
    step();
    chk("br_flush_valid", {31'd0, ValidD}, 32'd0);
    chk("br_flush_instr", InstrD, 32'h0);
    chk("br_old_addr", imem_addr, 32'hC);
    chk("br_busy", {31'd0, FetchBusyF}, 32'd1);
    PCSrcD = 1'b0;
    step();
    chk("br_old_addr2", imem_addr, 32'hC);
    chk("br_valid2", {31'd0, ValidD}, 32'd0);
    step();
    chk("br_new_addr", imem_addr, 32'h100);
    chk("br_valid3", {31'd0, ValidD}, 32'd0);
    chk("lat_busy", {31'd0, FetchBusyF}, 32'd1);
    step();
    chk("lat_addr1", imem_addr, 32'h100);
    chk("lat_bubble", {31'd0, ValidD}, 32'd0);
    step();
    chk("lat_addr2", imem_addr, 32'h100);
    chk("lat_busy_ack", {31'd0, FetchBusyF}, 32'd0);
    step();
    chk("lat_instr", InstrD, 32'hA5A5_0100);
    chk("lat_pc4", PCPlus4D, 32'h104);
    chk("lat_valid", {31'd0, ValidD}, 32'd1);
    chk("lat_next", imem_addr, 32'h104);

    // branch and jump together, with same-cycle ack
    lat = 0; PCSrcD = 1'b1; JumpD = 1'b1; PCBranchD = 32'h40; PCJumpD = 32'h80;
    step();
    chk("bj_addr", imem_addr, 32'h40);
    chk("bj_flush", {31'd0, ValidD}, 32'd0);
    PCSrcD = 1'b0; JumpD = 1'b0;
    step();
    chk("bj_instr", InstrD, 32'hA5A5_0040);
    chk("bj_addr2", imem_addr, 32'h44);

    // redirect during StallD=0 is ignored
    StallD = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h200;
    step();
    chk("ign_req", {31'd0, imem_req}, 32'd0);
    chk("ign_instr", InstrD, 32'hA5A5_0040);
    step();
    chk("ign_instr2", InstrD, 32'hA5A5_0040);
    PCSrcD = 1'b0; StallD = 1'b1;
    step();
    chk("ign_load", InstrD, 32'hA5A5_0044);
    chk("ign_pc", imem_addr, 32'h48);

    // StallF=0 keeps the PC but still delivers the acked word
    StallF = 1'b0;
    step();
    chk("sf_addr", imem_addr, 32'h48);
    chk("sf_instr", InstrD, 32'hA5A5_0048);
    StallF = 1'b1;
    step();
    chk("sf_addr2", imem_addr, 32'h4C);
    chk("sf_pc4", PCPlus4D, 32'h4C);

    // reset in the middle of DISCARD
    lat = 3; PCSrcD = 1'b1; PCBranchD = 32'h300;
    step();
    chk("dr_addr", imem_addr, 32'h4C);
    chk("dr_valid", {31'd0, ValidD}, 32'd0);
    PCSrcD = 1'b0;
    step();
    chk("dr_addr2", imem_addr, 32'h4C);
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_valid", {31'd0, ValidD}, 32'd0);
    chk("mrst_instr", InstrD, 32'h0);
    chk("mrst_pc4", PCPlus4D, 32'h0);
    chk("mrst_busy", {31'd0, FetchBusyF}, 32'd1);
    lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_req2", {31'd0, imem_req}, 32'd1);
    step();
    chk("mrst_instr2", InstrD, 32'hA5A5_0000);
    chk("mrst_addr4", imem_addr, 32'h4);

    // PC+4 wraps at the top of the address space
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    PCSrcD = 1'b0;
    step();
    chk("wrap_instr", InstrD, 32'h5A5A_FFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
